// File: rtl/mmio_periph_ctrl.sv
// Memory-mapped peripheral controller: LED register, scanned seven-segment
// display with hex decode, free-running system tick and a reloadable timer
// with a maskable level interrupt. Read data is registered.
module mmio_periph_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h40000000,
    parameter int unsigned LED_WIDTH      = 8,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter logic [15:0] SCAN_DIV_RESET = 16'd50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           i_address,
    input  logic                  i_control_read,
    input  logic                  i_control_write,
    input  logic [31:0]           i_control_write_data,
    output logic [31:0]           o_control_read_data,
    output logic [LED_WIDTH-1:0]  o_led,
    output logic [7:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_irq
);

    localparam int unsigned DIG_W = 5 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [31:0]          th;
    logic [31:0]          tl;
    logic                 en;
    logic                 ie;
    logic                 status;
    logic [LED_WIDTH-1:0] led;
    logic [DIG_W-1:0]     digits;
    logic [31:0]          systick;
    logic [15:0]          scan_div;
    logic [15:0]          scan_cnt;
    logic [IDX_W-1:0]     digit_idx;
    logic [31:0]          read_data;

    logic sel_th, sel_tl, sel_tcon, sel_led, sel_digits, sel_systick, sel_scan_div;
    logic [31:0] rd_mux;
    logic        overflow;
    logic [15:0] scan_last;
    logic [3:0]  nibble;
    logic        dp;
    logic [6:0]  seg_dec;

    assign sel_th       = (i_address == BASE_ADDR + 32'h00);
    assign sel_tl       = (i_address == BASE_ADDR + 32'h04);
    assign sel_tcon     = (i_address == BASE_ADDR + 32'h08);
    assign sel_led      = (i_address == BASE_ADDR + 32'h0C);
    assign sel_digits   = (i_address == BASE_ADDR + 32'h10);
    assign sel_systick  = (i_address == BASE_ADDR + 32'h14);
    assign sel_scan_div = (i_address == BASE_ADDR + 32'h18);

    assign overflow  = en && (tl == 32'hFFFF_FFFF);
    assign scan_last = (scan_div == 16'd0) ? 16'd0 : scan_div - 16'd1;

    // Read mux over pre-edge register values; unused bits read 0
    always_comb begin
        rd_mux = '0;
        if (sel_th) begin
            rd_mux = th;
        end else if (sel_tl) begin
            rd_mux = tl;
        end else if (sel_tcon) begin
            rd_mux[2:0] = {status, ie, en};
        end else if (sel_led) begin
            rd_mux[LED_WIDTH-1:0] = led;
        end else if (sel_digits) begin
            rd_mux[DIG_W-1:0] = digits;
        end else if (sel_systick) begin
            rd_mux = systick;
        end else if (sel_scan_div) begin
            rd_mux[15:0] = scan_div;
        end
    end

    // Register file, timer, system tick and scan counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            th        <= '0;
            tl        <= '0;
            en        <= 1'b0;
            ie        <= 1'b0;
            status    <= 1'b0;
            led       <= '0;
            digits    <= '0;
            systick   <= '0;
            scan_div  <= SCAN_DIV_RESET;
            scan_cnt  <= '0;
            digit_idx <= '0;
            read_data <= '0;
        end else begin
            read_data <= i_control_read ? rd_mux : '0;

            if (i_control_write && sel_th) begin
                th <= i_control_write_data;
            end

            // TL write has priority over both increment and reload
            if (i_control_write && sel_tl) begin
                tl <= i_control_write_data;
            end else if (en) begin
                tl <= overflow ? th : tl + 32'd1;
            end

            // Overflow set is applied after W1C so the set wins a collision
            if (i_control_write && sel_tcon) begin
                en <= i_control_write_data[0];
                ie <= i_control_write_data[1];
                if (i_control_write_data[2]) begin
                    status <= 1'b0;
                end
            end
            if (overflow) begin
                status <= 1'b1;
            end

            if (i_control_write && sel_led) begin
                led <= i_control_write_data[LED_WIDTH-1:0];
            end

            if (i_control_write && sel_digits) begin
                digits <= i_control_write_data[DIG_W-1:0];
            end

            if (i_control_write && sel_systick) begin
                systick <= i_control_write_data;
            end else begin
                systick <= systick + 32'd1;
            end

            // A divider write restarts the dwell on the current digit
            if (i_control_write && sel_scan_div) begin
                scan_div <= i_control_write_data[15:0];
                scan_cnt <= '0;
            end else if (scan_cnt >= scan_last) begin
                scan_cnt <= '0;
                if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
        end
    end

    // Select the active digit's nibble, dp flag and anode enable
    always_comb begin
        nibble = '0;
        dp     = 1'b0;
        o_an   = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                nibble  = digits[4*k +: 4];
                dp      = digits[4*NUM_DIGITS + k];
                o_an[k] = 1'b0;
            end
        end
    end

    // Active-low hex to seven-segment decode, [0]=a .. [6]=g
    always_comb begin
        case (nibble)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            4'hA:    seg_dec = 7'h08;
            4'hB:    seg_dec = 7'h03;
            4'hC:    seg_dec = 7'h46;
            4'hD:    seg_dec = 7'h21;
            4'hE:    seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    assign o_seg               = {~dp, seg_dec};
    assign o_led               = led;
    assign o_irq               = status & ie;
    assign o_control_read_data = read_data;

endmodule
